// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

  // Stall request encodings seen by pipeline control.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_side_buf.sv
// Per-requester done flag, result buffer and result mux (one instance each for IF and MEM).
module arb_side_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              live,       // bus ack for this side in this cycle
  input  logic [DATA_W-1:0] live_data,
  input  logic              load,       // completed, keep the result
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,      // pipeline advance or flush
  output logic              done,
  output logic              done_now,
  output logic [DATA_W-1:0] result
);

  logic              done_q;
  logic [DATA_W-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      if (load) buf_q <= load_data;
      // NOTE: clear wins over load so a result completing in the advance cycle is not carried into the next instruction.
      if (clear)     done_q <= 1'b0;
      else if (load) done_q <= 1'b1;
    end
  end

  assign done     = done_q;
  assign done_now = done_q | live;
  assign result   = live ? live_data : (done_q ? buf_q : '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory bus port between instruction fetch and load/store, data side first.
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ce,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_inst,
  input  logic              d_ce,
  input  logic              d_we,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  arb_state_e state;
  logic       busy, ack_live, ack_d, ack_i, timeout_hit, finish;
  logic       discard_q, drop, advance, clear;
  logic       done_d, done_i, done_now_d, done_now_i;
  logic       load_d, load_i;
  logic [DATA_W-1:0] load_data;

  assign busy     = (state != ARB_IDLE);
  assign ack_live = bus_ack & bus_req & busy;
  assign ack_d    = ack_live & (state == ARB_BUSY_D);
  assign ack_i    = ack_live & (state == ARB_BUSY_I);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign timeout_hit = busy & bus_req & ~bus_ack & (cnt == CNT_W'(TIMEOUT - 1));
  assign bus_err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!busy || finish) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  assign finish = ack_live | timeout_hit;
  // A flush seen at any point of the running cycle discards its result.
  assign drop      = flush_i | discard_q;
  assign advance   = (stallreq_o == NO_STOP);
  assign clear     = advance | flush_i;
  assign load_d    = (state == ARB_BUSY_D) & finish & ~drop;
  assign load_i    = (state == ARB_BUSY_I) & finish & ~drop;
  assign load_data = timeout_hit ? '0 : bus_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          discard_q <= 1'b0;
          if (d_ce && !done_d) begin
            state     <= ARB_BUSY_D;
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_sel   <= d_sel;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
          end else if (i_ce && !done_i) begin
            state     <= ARB_BUSY_I;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= '1;
            bus_addr  <= i_addr;
            bus_wdata <= '0;
          end
        end
        default: begin
          if (finish) begin
            state     <= ARB_IDLE;
            bus_req   <= 1'b0;
            discard_q <= 1'b0;
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
      endcase
    end
  end

  arb_side_buf #(.DATA_W(DATA_W)) u_side_i (
    .clk       (clk),
    .rst       (rst),
    .live      (ack_i),
    .live_data (bus_rdata),
    .load      (load_i),
    .load_data (load_data),
    .clear     (clear),
    .done      (done_i),
    .done_now  (done_now_i),
    .result    (i_inst)
  );

  arb_side_buf #(.DATA_W(DATA_W)) u_side_d (
    .clk       (clk),
    .rst       (rst),
    .live      (ack_d),
    .live_data (bus_rdata),
    .load      (load_d),
    .load_data (load_data),
    .clear     (clear),
    .done      (done_d),
    .done_now  (done_now_d),
    .result    (d_rdata)
  );

  assign stallreq_o = ((d_ce & ~done_now_d) | (i_ce & ~done_now_i)) ? STOP : NO_STOP;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the watchdog test is built when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ce, d_ce, d_we, flush_i, bus_ack;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_sel;
  logic [31:0] i_inst, d_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        stallreq_o, bus_req, bus_we, bus_err;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ce       (i_ce),
    .i_addr     (i_addr),
    .i_inst     (i_inst),
    .d_ce       (d_ce),
    .d_we       (d_we),
    .d_sel      (d_sel),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_sel    (bus_sel),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_ce = 1'b0; d_ce = 1'b0; d_we = 1'b0; flush_i = 1'b0; bus_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_sel = '0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    tick(); tick();
    #1;
    tests_run++;
    if ({bus_req, bus_we, bus_err, bus_sel, bus_addr, bus_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got req=%b we=%b err=%b sel=%h addr=%h wdata=%h, expected all 0",
               bus_req, bus_we, bus_err, bus_sel, bus_addr, bus_wdata);
    end
    tests_run++;
    if ({stallreq_o, i_inst, d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_results: got stall=%b i_inst=%h d_rdata=%h, expected 0/0/0", stallreq_o, i_inst, d_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    // A stray ack while idle must not count as a completion.
    i_ce = 1'b1; i_addr = 32'h100; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b1 || i_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL fetch_idle_ack: got stall=%b i_inst=%h, expected 1/00000000", stallreq_o, i_inst);
    end
    bus_ack = 1'b0;
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 || bus_sel !== 4'hF) begin
      tests_failed++;
      $display("FAIL fetch_issue: got req=%b addr=%h we=%b sel=%h, expected 1/00000100/0/f", bus_req, bus_addr, bus_we, bus_sel);
    end
    tick();
    tests_run++;
    if (stallreq_o !== 1'b1 || bus_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_wait: got stall=%b req=%b, expected 1/1", stallreq_o, bus_req);
    end
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h3401_0001;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b0 || i_inst !== 32'h3401_0001) begin
      tests_failed++;
      $display("FAIL fetch_ack: got stall=%b i_inst=%h, expected 0/34010001", stallreq_o, i_inst);
    end
    tick();
    quiet();
    #1;
    tests_run++;
    if (bus_req !== 1'b0 || i_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL fetch_after: got req=%b i_inst=%h, expected 0/00000000", bus_req, i_inst);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h200;
    i_ce = 1'b1; i_addr = 32'h104;
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_data_first: got req=%b addr=%h we=%b, expected 1/00000200/0", bus_req, bus_addr, bus_we);
    end
    bus_ack = 1'b1; bus_rdata = 32'hAAAA_0001;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b1 || d_rdata !== 32'hAAAA_0001) begin
      tests_failed++;
      $display("FAIL simul_data_ack: got stall=%b d_rdata=%h, expected 1/aaaa0001", stallreq_o, d_rdata);
    end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    tests_run++;
    if (bus_req !== 1'b0 || d_rdata !== 32'hAAAA_0001 || stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_gap: got req=%b d_rdata=%h stall=%b, expected 0/aaaa0001/1", bus_req, d_rdata, stallreq_o);
    end
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h104 || bus_sel !== 4'hF) begin
      tests_failed++;
      $display("FAIL simul_fetch_issue: got req=%b addr=%h sel=%h, expected 1/00000104/f", bus_req, bus_addr, bus_sel);
    end
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h5555_0002;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b0 || i_inst !== 32'h5555_0002 || d_rdata !== 32'hAAAA_0001) begin
      tests_failed++;
      $display("FAIL simul_fetch_ack: got stall=%b i_inst=%h d_rdata=%h, expected 0/55550002/aaaa0001",
               stallreq_o, i_inst, d_rdata);
    end
    tick();
    quiet();
    #1;
    tests_run++;
    if (bus_req !== 1'b0 || d_rdata !== 32'h0 || i_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL simul_advance: got req=%b d_rdata=%h i_inst=%h, expected 0/0/0", bus_req, d_rdata, i_inst);
    end
    tick();
  endtask

  task automatic test_load_during_fetch();
    i_ce = 1'b1; i_addr = 32'h108;
    tick();
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h204;
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h108) begin
      tests_failed++;
      $display("FAIL ldf_no_preempt: got req=%b addr=%h, expected 1/00000108", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h1111_0003;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b1 || i_inst !== 32'h1111_0003) begin
      tests_failed++;
      $display("FAIL ldf_fetch_ack: got stall=%b i_inst=%h, expected 1/11110003", stallreq_o, i_inst);
    end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h204 || i_inst !== 32'h1111_0003) begin
      tests_failed++;
      $display("FAIL ldf_data_issue: got req=%b addr=%h i_inst=%h, expected 1/00000204/11110003", bus_req, bus_addr, i_inst);
    end
    bus_ack = 1'b1; bus_rdata = 32'h2222_0004;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b0 || d_rdata !== 32'h2222_0004 || i_inst !== 32'h1111_0003) begin
      tests_failed++;
      $display("FAIL ldf_data_ack: got stall=%b d_rdata=%h i_inst=%h, expected 0/22220004/11110003",
               stallreq_o, d_rdata, i_inst);
    end
    tick();
    quiet();
    tick();
    tests_run++;
    if (bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL ldf_no_refetch: got req=%b, expected 0", bus_req);
    end
  endtask

  task automatic test_store();
    d_ce = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h300;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b0011 ||
          bus_addr !== 32'h300 || bus_wdata !== 32'hDEAD_BEEF) begin
        tests_failed++;
        $display("FAIL store_bus[%0d]: got req=%b we=%b sel=%h addr=%h wdata=%h, expected 1/1/3/00000300/deadbeef",
                 k, bus_req, bus_we, bus_sel, bus_addr, bus_wdata);
      end
      d_addr = 32'h3FC; d_wdata = 32'h0; d_sel = 4'hF;
      if (k < 2) tick();
    end
    bus_ack = 1'b1;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_ack: got stall=%b, expected 0", stallreq_o);
    end
    tick();
    quiet();
    tick();
  endtask

  task automatic test_flush();
    d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h400;
    i_ce = 1'b1; i_addr = 32'h500;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin
      tests_failed++;
      $display("FAIL flush_inflight: got req=%b addr=%h, expected 1/00000400", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h9999_0005;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0; d_ce = 1'b0;
    #1;
    tests_run++;
    if (bus_req !== 1'b0 || d_rdata !== 32'h0 || stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_discard: got req=%b d_rdata=%h stall=%b, expected 0/00000000/1", bus_req, d_rdata, stallreq_o);
    end
    tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h500) begin
      tests_failed++;
      $display("FAIL flush_idle_reissue: got req=%b addr=%h, expected 1/00000500", bus_req, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h7777_0006;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b0 || i_inst !== 32'h7777_0006) begin
      tests_failed++;
      $display("FAIL flush_fetch_ack: got stall=%b i_inst=%h, expected 0/77770006", stallreq_o, i_inst);
    end
    tick();
    quiet();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    i_ce = 1'b1; i_addr = 32'h600;
    tick();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    tests_run++;
    if ({bus_req, bus_we, bus_err, bus_sel, bus_addr, bus_wdata} !== '0 || i_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_busy: got req=%b we=%b err=%b sel=%h addr=%h i_inst=%h, expected all 0",
               bus_req, bus_we, bus_err, bus_sel, bus_addr, i_inst);
    end
    quiet();
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    i_ce = 1'b1; i_addr = 32'h700;
    tick(); tick(); tick(); tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_err !== 1'b0 || stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_4th_busy: got req=%b err=%b stall=%b, expected 1/0/1", bus_req, bus_err, stallreq_o);
    end
    tick();
    tests_run++;
    if (bus_req !== 1'b0 || bus_err !== 1'b1 || stallreq_o !== 1'b0 || i_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_abort: got req=%b err=%b stall=%b i_inst=%h, expected 0/1/0/00000000",
               bus_req, bus_err, stallreq_o, i_inst);
    end
    quiet();
    tick();
    tests_run++;
    if (bus_req !== 1'b0 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_err_pulse: got req=%b err=%b, expected 0/0", bus_req, bus_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    i_ce = 1'b1; i_addr = 32'h700;
    for (int k = 0; k < 8; k++) tick();
    tests_run++;
    if (bus_req !== 1'b1 || bus_err !== 1'b0 || stallreq_o !== 1'b1 || bus_addr !== 32'h700) begin
      tests_failed++;
      $display("FAIL no_timeout_wait: got req=%b err=%b stall=%b addr=%h, expected 1/0/1/00000700",
               bus_req, bus_err, stallreq_o, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    #1;
    tests_run++;
    if (stallreq_o !== 1'b0 || i_inst !== 32'h0BAD_F00D) begin
      tests_failed++;
      $display("FAIL no_timeout_ack: got stall=%b i_inst=%h, expected 0/0badf00d", stallreq_o, i_inst);
    end
    tick();
    quiet();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_load_during_fetch();
    test_store();
    test_flush();
    test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory bus port between instruction fetch (IF side) and load/store (MEM side) of the five-stage pipeline.
- Serialises the two requesters and always serves the data side first.
- Buffers completed results until the pipeline advances.
- Raises a stall request to the pipeline control logic while either side is unfinished.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- TIMEOUT, 255, bus watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_ce  in  1  instruction fetch request.
- i_addr  in  ADDR_W  fetch address (pc).
- i_inst  out  DATA_W  fetched instruction.
- d_ce  in  1  data access request.
- d_we  in  1  1 = store.
- d_sel  in  SEL_W  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- flush_i  in  1  pipeline flush; drop buffered results.
- stallreq_o  out  1  stall request to pipeline control.
- bus_req  out  1  bus cycle request.
- bus_we  out  1  bus write.
- bus_sel  out  SEL_W  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data.
- bus_ack  in  1  bus cycle complete.
- bus_err  out  1  watchdog abort pulse; tied 0 without the macro.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: FSM = IDLE; bus_req, bus_we, bus_err = 0; bus_sel, bus_addr, bus_wdata = 0; both done flags and buffers = 0.
- Per-side state:
  - done flag plus result buffer (i_buf, d_buf).
  - done_now_x = done_x | (ack in BUSY_x this cycle).
- stallreq_o (combinational) = (d_ce & ~done_now_d) | (i_ce & ~done_now_i).
- Result outputs:
  - i_inst = bus_rdata when ack in BUSY_I, else i_buf if done_i, else 0.
  - d_rdata follows the same rule with BUSY_D and d_buf.
- FSM states: IDLE, BUSY_D, BUSY_I.
  - IDLE: if d_ce & ~done_d, go to BUSY_D and register d_addr/d_we/d_sel/d_wdata onto the bus outputs, bus_req=1.
  - IDLE, else: if i_ce & ~done_i, go to BUSY_I with bus_addr=i_addr, we=0, sel=all ones, bus_req=1.
  - IDLE, else: stay in IDLE.
  - BUSY_x: hold all bus outputs stable until bus_ack.
  - BUSY_x on ack: capture bus_rdata into x_buf, set done_x, clear bus_req, go to IDLE.
  - Next request issues no earlier than the cycle after returning to IDLE.
- Ack handling:
  - bus_ack is ignored while bus_req=0.
  - Minimum latency is request seen at cycle N, bus_req at N+1, earliest ack at N+1, stallreq_o low in the ack cycle.
- Pipeline advance: at any edge with stallreq_o=0, clear both done flags; the next instruction's requests are new.
- No preemption: a running instruction fetch finishes before a newly arriving data request.
  - The fetch result is held in i_buf; fetch is not reissued.
- Store: bus_rdata is captured but meaningless; d_rdata is not defined for stores.
- flush_i:
  - Clears done flags at the next edge.
  - An in-flight bus cycle still completes, but its result is discarded and its done flag is not set.
  - The FSM returns to IDLE on ack.
- rst mid-transaction: bus_req drops the next cycle and the pending ack is ignored.
  - The bus slave must tolerate an abandoned cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in BUSY_x and resets on entering BUSY.
  - When the count reaches TIMEOUT without ack: drop bus_req, pulse bus_err for 1 cycle, set done_x with x_buf = 0, go to IDLE.
  - The pipeline therefore resumes.
- Undefined: no counter, bus_err = 0, and BUSY waits for ack indefinitely.

Decomposition:
- defines.v holds:
  - FSM state codes ARB_IDLE/ARB_BUSY_D/ARB_BUSY_I;
  - the default TIMEOUT;
  - the Stop/NoStop encodings for stallreq_o.
- One natural sub-module, arb_side_buf: done flag, result buffer, output mux and done_now.
  - Instantiated twice, once for IF and once for MEM.

Test Plan:
- Fetch only:
  - Stimulus: i_ce=1, i_addr=0x100, slave acks 2 cycles after bus_req with 0x34010001.
  - Required: bus_addr=0x100, bus_we=0; stallreq_o high until the ack cycle; i_inst=0x34010001 in the ack cycle.
- Simultaneous fetch and load:
  - Stimulus: d_addr=0x200 and i_addr=0x104 asserted together.
  - Required: data cycle issued first; after its ack, the fetch at 0x104 is issued; stallreq_o falls only in the second ack cycle; d_rdata held from d_buf.
- Load arrives during fetch:
  - Stimulus: d_ce rises while BUSY_I.
  - Required: fetch completes, i_buf retains its value, the data cycle follows, and no second fetch is issued.
- Store:
  - Stimulus: d_we=1, d_sel=4'b0011, d_wdata=0xDEADBEEF, d_addr=0x300.
  - Required: bus outputs match exactly and stay stable until ack.
- Flush during BUSY_D:
  - Required: transaction completes on the bus, done_d stays 0, FSM returns to IDLE, and nothing is buffered.
- With ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks:
  - Required: bus_req drops after 4 BUSY cycles, bus_err pulses once, stallreq_o deasserts and i_inst=0.
  - Reset asserted mid-BUSY returns all outputs to their reset values on the next edge.
